// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the scheduler state enum, digit/ID widths and the add-3 correction.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 3;
    localparam int ID_W       = 3;

    // Double-dabble correction: a digit of 5 or more would exceed 9
    // after the next shift, so pre-bias it by 3.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set req bit at or above ptr, wrapping.
// Ports: req/ptr/en in; grant (one-hot) and idx (binary) out, zero when idle.
module rr_arbiter
    import bcd_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic found;
    int   pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (en && !found && k == pos && req[k]) begin
                    found    = 1'b1;
                    grant[k] = 1'b1;
                    idx      = ID_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shared shift-add-3 binary-to-BCD converter, one bit per clock, with a
// round-robin front end.
// Ports: clk, rst_n (sync, active-low), req/bin_in per requester in;
// gnt (one-hot pulse), busy, done (pulse), done_id, hundreds/tens/ones out.
module bcd_conv_scheduler
    import bcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] bin_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [3:0]               hundreds,
    output logic [3:0]               tens,
    output logic [3:0]               ones
);

    state_t state, state_nxt;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    cur_id;
    logic [WIDTH-1:0]   sr;
    logic [WIDTH-1:0]   operand;
    logic [3:0]         d2, d1, d0;
    logic [3:0]         c2, c1, c0;
    logic [3:0]         cnt;
    logic               accept;
    logic               last;

    // Corrected digits and shift register moved left as one wide word.
    logic [4*BCD_DIGITS+WIDTH-1:0] shv;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .en    (state != SHIFT),
        .grant (arb_gnt),
        .idx   (arb_idx)
    );

    assign operand = bin_in[int'(arb_idx)*WIDTH +: WIDTH];
    assign c2      = add3_if_ge5(d2);
    assign c1      = add3_if_ge5(d1);
    assign c0      = add3_if_ge5(d0);
    assign shv     = {c2, c1, c0, sr} << 1;
    assign busy    = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (|req) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (cnt == 4'd1) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt      <= '0;
            done     <= 1'b0;
            done_id  <= '0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
            ptr      <= '0;
            cur_id   <= '0;
            sr       <= '0;
            d2       <= '0;
            d1       <= '0;
            d0       <= '0;
            cnt      <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            if (accept) begin
                gnt    <= arb_gnt;
                ptr    <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                cur_id <= arb_idx;
                sr     <= operand;
                d2     <= '0;
                d1     <= '0;
                d0     <= '0;
                cnt    <= 4'(WIDTH);
            end else if (state == SHIFT) begin
                d2  <= shv[WIDTH+11:WIDTH+8];
                d1  <= shv[WIDTH+7:WIDTH+4];
                d0  <= shv[WIDTH+3:WIDTH];
                sr  <= shv[WIDTH-1:0];
                cnt <= cnt - 4'd1;
                if (last) begin
                    hundreds <= shv[WIDTH+11:WIDTH+8];
                    tens     <= shv[WIDTH+7:WIDTH+4];
                    ones     <= shv[WIDTH+3:WIDTH];
                    done_id  <= cur_id;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Testbench for bcd_conv_scheduler: vector table plus scoreboard.
// Drives requests, models BCD digits, checks grant order and timing.
module tb_bcd_conv_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] bin_in;
    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic                     done;
    logic [2:0]               done_id;
    logic [3:0]               hundreds, tens, ones;

    bcd_conv_scheduler #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .bin_in   (bin_in),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int val;
        int h;
        int t;
        int o;
    } vec_t;

    vec_t        tbl[8];
    logic [14:0] sb[$];
    int          glog[$];
    int          dlog[$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [WIDTH-1:0] mon_v;

    function automatic logic [14:0] model(int id, int v);
        return {3'(id), 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Scoreboard: expected result pushed at grant, compared at done.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (gnt != '0) begin
            check("gnt_onehot", int'($onehot(gnt)), 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    glog.push_back(i);
                    mon_v = bin_in[i*WIDTH +: WIDTH];
                    sb.push_back(model(i, int'(mon_v)));
                end
            end
        end
        if (done) begin
            dlog.push_back(cyc);
            if (sb.size() == 0)
                check("sb_underflow", 0, 1);
            else
                check("sb_result",
                      int'({done_id, hundreds, tens, ones}),
                      int'(sb.pop_front()));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(int id, int val);
        bin_in[id*WIDTH +: WIDTH] = WIDTH'(val);
    endtask

    function automatic int outs_all();
        return int'({gnt, busy, done, done_id, hundreds, tens, ones});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        req   = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        glog.delete();
        dlog.delete();
    endtask

    task automatic wait_gnt(int id, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (gnt[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic run_req(vec_t v);
        bit ok;
        @(negedge clk);
        set_op(v.id, v.val);
        req[v.id] = 1'b1;
        wait_gnt(v.id, ok);
        req[v.id] = 1'b0;
        if (ok) begin
            wait_done(ok);
            if (ok) begin
                check("tbl_digits", int'({hundreds, tens, ones}),
                      v.h * 256 + v.t * 16 + v.o);
                check("tbl_id", int'(done_id), v.id);
            end
        end
    endtask

    initial begin
        int   g_at, d_at, bz, n;
        bit   ok;
        int   exp_order[5];
        vec_t v;

        tbl[0] = '{0, 255, 2, 5, 5};
        tbl[1] = '{2,   0, 0, 0, 0};
        tbl[2] = '{2,   9, 0, 0, 9};
        tbl[3] = '{2, 100, 1, 0, 0};
        tbl[4] = '{3,  42, 0, 4, 2};
        tbl[5] = '{1, 199, 1, 9, 9};
        tbl[6] = '{3, 128, 1, 2, 8};
        tbl[7] = '{0,   1, 0, 0, 1};
        exp_order = '{0, 1, 2, 3, 0};

        req    = '0;
        bin_in = '0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs_all(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", outs_all(), 0);

        // Latency of a single conversion
        @(negedge clk);
        set_op(0, 255);
        req[0] = 1'b1;
        g_at = -1;
        d_at = -1;
        bz   = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (gnt[0] && g_at < 0) begin
                g_at   = k;
                req[0] = 1'b0;
            end
            if (busy) bz++;
            if (done && d_at < 0) begin
                d_at = k;
                check("lat_digits", int'({hundreds, tens, ones}), 'h255);
                check("lat_id", int'(done_id), 0);
            end
        end
        check("gnt_latency", g_at, 1);
        check("busy_cycles", bz, 8);
        check("done_latency", d_at, 9);

        for (int i = 0; i < 8; i++) run_req(tbl[i]);

        // All requesters held high: round-robin, no gap between results
        do_reset();
        @(negedge clk);
        set_op(0, 17);
        set_op(1, 64);
        set_op(2, 250);
        set_op(3, 7);
        req = '1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (glog.size() >= 5) req = '0;
            if (req == '0 && sb.size() == 0) break;
        end
        for (int k = 0; k < 5; k++)
            check("rr_order", (k < glog.size()) ? glog[k] : -1, exp_order[k]);
        check("rr_dones", dlog.size(), 5);
        for (int k = 0; k < 4; k++)
            check("rr_gap",
                  (k + 1 < dlog.size()) ? dlog[k+1] - dlog[k] : -1, 9);

        // Pointer after grant 1 is 2, so 0 wins over 1
        do_reset();
        v = '{1, 33, 0, 3, 3};
        run_req(v);
        @(negedge clk);
        glog.delete();
        set_op(0, 60);
        set_op(1, 61);
        req = 4'b0011;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (gnt[0]) req[0] = 1'b0;
            if (gnt[1]) req[1] = 1'b0;
            if (req == '0 && sb.size() == 0) break;
        end
        check("ptr_first", (glog.size() > 0) ? glog[0] : -1, 0);
        check("ptr_second", (glog.size() > 1) ? glog[1] : -1, 1);

        // Reset during the 4th shift cycle aborts the conversion
        @(negedge clk);
        set_op(0, 200);
        req[0] = 1'b1;
        wait_gnt(0, ok);
        req[0] = 1'b0;
        repeat (3) tick();
        check("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        check("mid_reset_outs", outs_all(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        n = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) n++;
        end
        check("abort_no_done", n, 0);
        v = '{3, 42, 0, 4, 2};
        run_req(v);

        // One-cycle req[1] during SHIFT is never served
        @(negedge clk);
        glog.delete();
        set_op(0, 77);
        req[0] = 1'b1;
        wait_gnt(0, ok);
        req[0] = 1'b0;
        @(negedge clk);
        set_op(1, 55);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        wait_done(ok);
        check("wd_digits", int'({hundreds, tens, ones}), 'h077);
        check("wd_id", int'(done_id), 0);
        repeat (12) tick();
        check("wd_grants", glog.size(), 1);
        check("wd_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
